spi_master_full: RTL and testbench

- SPI master that serialises one wide frame to the team's 392-bit SPI slave and captures the slave's reply in the same transfer.
- Sits upstream of the slave: the AES datapath loads a full frame, pulses start, and later collects the received frame when done pulses.
- Mode 0 (CPOL=0), MSB first, full duplex, single chip select (active low).

---
 rtl/spi_master_full.sv | 149 ++++++++++++++
 tb/tb_spi_master_full.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_full.sv
// Mode-0 SPI master: shifts one FRAME_BITS-wide frame out on mosi MSB first while
// capturing miso, then holds cs high for a short gap so the slave can reload.
module spi_master_full #(
  parameter int FRAME_BITS = 392,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] data_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] data_out_q, data_out_d;
  logic                  hold_ph_q, hold_ph_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  div_last;

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_last ? '0 : div_q + DIV_W'(1);
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    hold_ph_d  = hold_ph_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          tx_d    = data_in;
          rx_d    = '0;
          bit_d   = '0;
          mosi_d  = data_in[FRAME_BITS-1];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP, LOW: begin
        if (div_last) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[FRAME_BITS-2:0], miso};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (div_last) begin
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            hold_ph_d = 1'b0;
            state_d   = HOLD;
          end else begin
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[FRAME_BITS-2];
            bit_d   = bit_q + BIT_W'(1);
            state_d = LOW;
          end
        end
      end
      HOLD: begin
        // Two divider periods: the final sclk-low half-bit, then the cs hold time.
        if (div_last) begin
          if (!hold_ph_q) begin
            hold_ph_d = 1'b1;
          end else begin
            cs_d       = 1'b1;
            mosi_d     = 1'b0;
            data_out_d = rx_q;
            done_d     = 1'b1;
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        if (div_last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      hold_ph_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      hold_ph_q  <= hold_ph_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs       = cs_q;
endmodule

// File: tb/tb_spi_master_full.sv
// Directed bench for spi_master_full: a small 8-bit instance with a miso reply model,
// plus a default-size instance against a behavioural 392-bit slave.
module tb_spi_master_full;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Small instance: FRAME_BITS=8, CLK_DIV=2
  logic       start_a = 1'b0;
  logic [7:0] din_a = 8'h00;
  logic [7:0] dout_a;
  logic       busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
  logic [7:0] reply_a = 8'h3C;

  spi_master_full #(.FRAME_BITS(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_in(din_a), .data_out(dout_a),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs(cs_a)
  );

  // Default instance: FRAME_BITS=392, CLK_DIV=4
  logic         start_b = 1'b0;
  logic [391:0] din_b = '0;
  logic [391:0] dout_b;
  logic         busy_b, done_b, sclk_b, mosi_b, miso_b, cs_b;
  logic [391:0] pat_b;

  spi_master_full dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_in(din_b), .data_out(dout_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs(cs_b)
  );

  // Reply model for the small instance: load while cs high, advance on each sclk fall
  logic [7:0] sh_a;
  logic       sclk_a_prev;
  always @(negedge clk) begin
    sclk_a_prev <= sclk_a;
    if (cs_a) sh_a <= reply_a;
    else if (sclk_a_prev && !sclk_a) sh_a <= {sh_a[6:0], 1'b0};
  end
  assign miso_a = sh_a[7];

  // Behavioural 392-bit slave: samples mosi on sclk rise, shifts its reply on sclk fall
  logic [391:0] sh_b, slave_rx_b;
  logic         sclk_b_prev;
  int           slave_rises_b;
  always @(negedge clk) begin
    sclk_b_prev <= sclk_b;
    if (reset) slave_rises_b <= 0;
    if (cs_b) sh_b <= ~pat_b;
    else begin
      if (sclk_b_prev && !sclk_b) sh_b <= {sh_b[390:0], 1'b0};
      if (!sclk_b_prev && sclk_b) begin
        slave_rx_b    <= {slave_rx_b[390:0], mosi_b};
        if (!reset) slave_rises_b <= slave_rises_b + 1;
      end
    end
  end
  assign miso_b = sh_b[391];

  int checks = 0;
  int failures = 0;

  // Observations collected by watch_a
  logic [15:0] w_bits;
  int w_rises, w_high, w_cslow, w_dones, w_done_at, w_gap;

  task automatic watch_a(input int ncyc, input int inject_at, input bit hold);
    logic prev_sclk, seen_low, gap_done;
    w_bits = '0; w_rises = 0; w_high = 0; w_cslow = 0; w_dones = 0; w_done_at = -1; w_gap = 0;
    prev_sclk = 1'b0; seen_low = 1'b0; gap_done = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (sclk_a && !prev_sclk) begin
        w_rises++;
        w_bits = {w_bits[14:0], mosi_a};
      end
      if (sclk_a) w_high++;
      prev_sclk = sclk_a;
      if (!cs_a) begin
        w_cslow++;
        if (seen_low && w_gap > 0) gap_done = 1'b1;
        seen_low = 1'b1;
      end else if (seen_low && !gap_done) begin
        w_gap++;
      end
      if (done_a) begin
        w_dones++;
        if (w_done_at < 0) w_done_at = i - 1;
      end
      if (i == 1 && !hold) start_a = 1'b0;
      if (i == 1 && hold) din_a = 8'h7E;
      if (inject_at > 0 && i == inject_at) begin start_a = 1'b1; din_a = 8'hFF; end
      if (inject_at > 0 && i == inject_at + 1) start_a = 1'b0;
      if (hold && gap_done) start_a = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cs_a !== 1'b1) begin failures++; $display("FAIL reset_cs got=%0b exp=1", cs_a); end
    checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%0b exp=0", sclk_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || mosi_a !== 1'b0) begin failures++; $display("FAIL reset_ctl got=%0b%0b%0b exp=000", busy_a, done_a, mosi_a); end
    checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout_a); end
    checks++; if (cs_b !== 1'b1 || dout_b !== '0) begin failures++; $display("FAIL reset_b got_cs=%0b exp=1", cs_b); end
    // Asynchronous assertion mid-frame, between clock edges
    din_a = 8'hFF; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (cs_a !== 1'b1 || busy_a !== 1'b0 || mosi_a !== 1'b0 || sclk_a !== 1'b0) begin failures++; $display("FAIL async_reset got cs=%0b busy=%0b mosi=%0b sclk=%0b exp 1000", cs_a, busy_a, mosi_a, sclk_a); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    reply_a = 8'h3C; din_a = 8'hA5; start_a = 1'b1;
    watch_a(50, 0, 1'b0);
    checks++; if (w_bits[7:0] !== 8'hA5) begin failures++; $display("FAIL single_mosi got=%0h exp=a5", w_bits[7:0]); end
    checks++; if (w_rises !== 8) begin failures++; $display("FAIL single_rises got=%0d exp=8", w_rises); end
    checks++; if (w_high !== 16) begin failures++; $display("FAIL single_high got=%0d exp=16", w_high); end
    checks++; if (w_cslow !== 36) begin failures++; $display("FAIL single_cslow got=%0d exp=36", w_cslow); end
    checks++; if (w_done_at !== 36) begin failures++; $display("FAIL single_done_at got=%0d exp=36", w_done_at); end
    checks++; if (w_dones !== 1) begin failures++; $display("FAIL single_dones got=%0d exp=1", w_dones); end
    checks++; if (dout_a !== 8'h3C) begin failures++; $display("FAIL single_dout got=%0h exp=3c", dout_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0b exp=0", busy_a); end
  endtask

  task automatic test_busy_reject;
    reply_a = 8'hC3; din_a = 8'hA5; start_a = 1'b1;
    watch_a(60, 10, 1'b0);
    checks++; if (w_bits[7:0] !== 8'hA5) begin failures++; $display("FAIL reject_mosi got=%0h exp=a5", w_bits[7:0]); end
    checks++; if (w_dones !== 1) begin failures++; $display("FAIL reject_dones got=%0d exp=1", w_dones); end
    checks++; if (w_rises !== 8) begin failures++; $display("FAIL reject_rises got=%0d exp=8", w_rises); end
    checks++; if (dout_a !== 8'hC3) begin failures++; $display("FAIL reject_dout got=%0h exp=c3", dout_a); end
  endtask

  task automatic test_back_to_back;
    reply_a = 8'h69; din_a = 8'h81; start_a = 1'b1;
    watch_a(100, 0, 1'b1);
    checks++; if (w_bits !== 16'h817E) begin failures++; $display("FAIL b2b_mosi got=%0h exp=817e", w_bits); end
    checks++; if (w_dones !== 2) begin failures++; $display("FAIL b2b_dones got=%0d exp=2", w_dones); end
    checks++; if (w_gap !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", w_gap); end
    checks++; if (w_cslow !== 72) begin failures++; $display("FAIL b2b_cslow got=%0d exp=72", w_cslow); end
    checks++; if (dout_a !== 8'h69) begin failures++; $display("FAIL b2b_dout got=%0h exp=69", dout_a); end
  endtask

  task automatic test_mid_frame_reset;
    int rises;
    logic prev;
    reply_a = 8'h99; din_a = 8'hA5; start_a = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 60 && rises < 4; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
    end
    checks++; if (rises !== 4) begin failures++; $display("FAIL midreset_reach got=%0d exp=4", rises); end
    #2 reset = 1'b1;
    #1;
    checks++; if (cs_a !== 1'b1 || done_a !== 1'b0 || sclk_a !== 1'b0) begin failures++; $display("FAIL midreset_ctl got cs=%0b done=%0b sclk=%0b exp 100", cs_a, done_a, sclk_a); end
    checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL midreset_dout got=%0h exp=0", dout_a); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL midreset_idle got done=%0b busy=%0b exp 00", done_a, busy_a); end
    reply_a = 8'h96; din_a = 8'h5A; start_a = 1'b1;
    watch_a(50, 0, 1'b0);
    checks++; if (w_bits[7:0] !== 8'h5A) begin failures++; $display("FAIL after_reset_mosi got=%0h exp=5a", w_bits[7:0]); end
    checks++; if (dout_a !== 8'h96 || w_dones !== 1) begin failures++; $display("FAIL after_reset_dout got=%0h dones=%0d exp=96 dones=1", dout_a, w_dones); end
  endtask

  task automatic test_default_slave;
    int done_at, dones, cslow;
    for (int k = 0; k < 49; k++) pat_b[k*8 +: 8] = k[7:0];
    @(negedge clk);
    din_b = pat_b; start_b = 1'b1;
    done_at = -1; dones = 0; cslow = 0;
    for (int i = 1; i <= 3300; i++) begin
      @(negedge clk);
      if (i == 1) start_b = 1'b0;
      if (!cs_b) cslow++;
      if (done_b) begin
        dones++;
        if (done_at < 0) done_at = i - 1;
      end
    end
    checks++; if (done_at !== 3144) begin failures++; $display("FAIL big_done_at got=%0d exp=3144", done_at); end
    checks++; if (cslow !== 3144) begin failures++; $display("FAIL big_cslow got=%0d exp=3144", cslow); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL big_dones got=%0d exp=1", dones); end
    checks++; if (dout_b !== ~pat_b) begin failures++; $display("FAIL big_dout got_lo=%0h exp_lo=%0h", dout_b[63:0], ~pat_b[63:0]); end
    checks++; if (slave_rx_b !== pat_b) begin failures++; $display("FAIL big_slave_rx got_lo=%0h exp_lo=%0h", slave_rx_b[63:0], pat_b[63:0]); end
    checks++; if (slave_rises_b !== 392) begin failures++; $display("FAIL big_rises got=%0d exp=392", slave_rises_b); end
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL big_busy_end got=%0b exp=0", busy_b); end
  endtask

  initial begin
    pat_b = '0;
    test_reset();
    test_single_frame();
    test_busy_reject();
    test_back_to_back();
    test_mid_frame_reset();
    test_default_slave();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
